// File: rtl/mbd_pkg.sv
// Shared definitions for multi_button_debouncer: channel FSM encoding, default
// timing constants and the counter-width helper.
package mbd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    HOLD_WAIT,
    REPEAT,
    DEB_RELEASE
  } state_e;

  localparam int DEF_N_BTN           = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_MCEN_DELAY      = 25000000;
  localparam int DEF_MCEN_PERIOD     = 5000000;

  // Width that holds the largest of the three terminal counts, plus one bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/mbd_channel.sv
// One button channel: 2-FF synchroniser, debounce/repeat FSM, shared counter and
// registered pulse outputs. rel exists only when MBD_RELEASE_PULSE_EN is defined.
module mbd_channel
  import mbd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int MCEN_DELAY      = DEF_MCEN_DELAY,
  parameter int MCEN_PERIOD     = DEF_MCEN_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic dpb,
  output logic scen,
  output logic mcen,
`ifdef MBD_RELEASE_PULSE_EN
  output logic rel,
`endif
  output logic ccen
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, MCEN_DELAY, MCEN_PERIOD);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  // HOLD_WAIT spans MCEN_DELAY+1 cycles so the first repeat lands that far after the press pulse.
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(MCEN_DELAY);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(MCEN_PERIOD - 1);

  logic [1:0]       sync;
  logic             s;
  logic [CNT_W-1:0] cnt;
  state_e           state;

  assign s    = sync[1];
  assign ccen = dpb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b00;
      state <= IDLE;
      cnt   <= '0;
      dpb   <= 1'b0;
      scen  <= 1'b0;
      mcen  <= 1'b0;
`ifdef MBD_RELEASE_PULSE_EN
      rel   <= 1'b0;
`endif
    end else begin
      sync <= {sync[0], button};
      scen <= 1'b0;
      mcen <= 1'b0;
`ifdef MBD_RELEASE_PULSE_EN
      rel  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (s) begin
            state <= DEB_PRESS;
            cnt   <= CNT_W'(1);
          end
        end
        DEB_PRESS: begin
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state <= HOLD_WAIT;
            cnt   <= '0;
            scen  <= 1'b1;
            mcen  <= 1'b1;
            dpb   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD_WAIT: begin
          if (!s) begin
            state <= DEB_RELEASE;
            cnt   <= CNT_W'(1);
          end else if (cnt == DELAY_LAST) begin
            state <= REPEAT;
            cnt   <= '0;
            mcen  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (!s) begin
            state <= DEB_RELEASE;
            cnt   <= CNT_W'(1);
          end else if (cnt == PERIOD_LAST) begin
            cnt  <= '0;
            mcen <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DEB_RELEASE: begin
          // A return to 1 here is a bounce: the press stays, only repeat timing restarts.
          if (s) begin
            state <= HOLD_WAIT;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            dpb   <= 1'b0;
`ifdef MBD_RELEASE_PULSE_EN
            rel   <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_button_debouncer.sv
// N-channel push-button conditioner (debounced level, press, repeat and hold enables).
// Define MBD_RELEASE_PULSE_EN to add the rels release-pulse port.
module multi_button_debouncer
  import mbd_pkg::*;
#(
  parameter int N_BTN           = DEF_N_BTN,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int MCEN_DELAY      = DEF_MCEN_DELAY,
  parameter int MCEN_PERIOD     = DEF_MCEN_PERIOD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] buttons,
  output logic [N_BTN-1:0] dpbs,
  output logic [N_BTN-1:0] scens,
  output logic [N_BTN-1:0] mcens,
`ifdef MBD_RELEASE_PULSE_EN
  output logic [N_BTN-1:0] rels,
`endif
  output logic [N_BTN-1:0] ccens
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    mbd_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .MCEN_DELAY     (MCEN_DELAY),
      .MCEN_PERIOD    (MCEN_PERIOD)
    ) u_chan (
      .clk   (clk),
      .rst_n (reset),
      .button(buttons[i]),
      .dpb   (dpbs[i]),
      .scen  (scens[i]),
      .mcen  (mcens[i]),
`ifdef MBD_RELEASE_PULSE_EN
      .rel   (rels[i]),
`endif
      .ccen  (ccens[i])
    );
  end

endmodule
